sseg_scan_ctrl: RTL and testbench

Parametrised seven-segment scan controller that time-multiplexes NUM_DIGITS hex/BCD digits onto a shared active-low segment bus. It adds the following:
- a per-digit decimal-point mask
- optional leading-zero blanking
- a hex/dash decode mode
- PWM brightness control
- frame-coherent input shadowing, so a display never shows a torn value

It sits between the stopwatch/counter datapath and the board's anode/cathode pins.

---
 rtl/sseg_pkg.sv | 29 ++
 rtl/sseg_scan_ctrl_if.sv | 24 ++
 rtl/sseg_decode.sv | 34 +++
 rtl/sseg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low {g,f,e,d,c,b,a}
// segment patterns and the digit-index width helper.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Never returns 0, so a 1-digit build still gets a legal 1-bit index.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Bundle between the counter datapath (master) and the scan controller (slave).
interface sseg_scan_ctrl_if #(
  parameter int NUM_DIGITS   = 4,
  parameter int BRIGHT_WIDTH = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic                    blank_lz;
  logic [BRIGHT_WIDTH-1:0] brightness;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_start;

  modport master (
    output digits, dp_en, blank_lz, brightness,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  digits, dp_en, blank_lz, brightness,
    output seg_n, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/sseg_decode.sv
// Combinational 4-bit code to active-low segment pattern; codes 10..15 are
// hex letters or a dash depending on hex_mode.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (code)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = hex_mode ? SEG_A : SEG_DASH;
      4'hB: seg_n = hex_mode ? SEG_B : SEG_DASH;
      4'hC: seg_n = hex_mode ? SEG_C : SEG_DASH;
      4'hD: seg_n = hex_mode ? SEG_D : SEG_DASH;
      4'hE: seg_n = hex_mode ? SEG_E : SEG_DASH;
      4'hF: seg_n = hex_mode ? SEG_F : SEG_DASH;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-coherent shadowing,
// leading-zero blanking, decimal points and PWM brightness.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int BRIGHT_WIDTH = 4,
  parameter int HEX_MODE     = 0
) (
  input  logic             clock,
  input  logic             reset,
  sseg_scan_ctrl_if.slave  bus
);

  localparam int            IW       = idx_width(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]    presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_blz_q, sh_blz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    slot_tick;
  logic                    frame_wrap;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              dec_seg;

  // Scan timing: prescaler, digit index and the frame boundary
  always_comb begin
    slot_tick  = &presc_q;
    frame_wrap = slot_tick && (idx_q == LAST_IDX);
    presc_d    = presc_q + DIV_WIDTH'(1);
    idx_d      = idx_q;
    if (slot_tick) idx_d = frame_wrap ? '0 : idx_q + IW'(1);
    fs_d        = frame_wrap;
    sh_digits_d = frame_wrap ? bus.digits   : sh_digits_q;
    sh_dp_d     = frame_wrap ? bus.dp_en    : sh_dp_q;
    sh_blz_d    = frame_wrap ? bus.blank_lz : sh_blz_q;
  end

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    logic all_zero;
    blank_vec = '0;
    all_zero  = 1'b1;
    for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
      all_zero     = all_zero && (sh_digits_q[4*j +: 4] == 4'h0);
      blank_vec[j] = sh_blz_q && all_zero;
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = sh_digits_q[4*i +: 4];
        cur_dp    = sh_dp_q[i];
        cur_blank = blank_vec[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  sseg_decode u_decode (
    .code     (cur_code),
    .hex_mode (HEX_MODE != 0),
    .seg_n    (dec_seg)
  );

  // Output stage: anode, segments and dp all come from the same index snapshot.
  always_comb begin
    pwm_on = presc_q[DIV_WIDTH-1 -: BRIGHT_WIDTH] < bus.brightness;
    seg_d  = cur_blank ? SEG_BLANK : dec_seg;
    dp_d   = ~cur_dp;
    an_d   = (pwm_on && !slot_tick) ? ~an_sel : '1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_blz_q    <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= '1;
      fs_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_blz_q    <= sh_blz_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
    end
  end

  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.an_n        = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: three instances (decimal, hex, six-digit).
module tb_sseg_scan_ctrl;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P7 = 7'b1111000;
  localparam logic [6:0] PA = 7'b0001000, PB = 7'b0000011, PC = 7'b1000110;
  localparam logic [6:0] PF = 7'b0001110, PDASH = 7'b0111111, PBLK = 7'b1111111;

  logic clk = 1'b0;
  logic rst_ab = 1'b1;
  logic rst_c  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_WIDTH(4)) ifa ();
  sseg_scan_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_WIDTH(4)) ifb ();
  sseg_scan_ctrl_if #(.NUM_DIGITS(6), .BRIGHT_WIDTH(4)) ifc ();

  sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(4), .BRIGHT_WIDTH(4), .HEX_MODE(0)) dut_a (
    .clock(clk), .reset(rst_ab), .bus(ifa.slave));
  sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(4), .BRIGHT_WIDTH(4), .HEX_MODE(1)) dut_b (
    .clock(clk), .reset(rst_ab), .bus(ifb.slave));
  sseg_scan_ctrl #(.NUM_DIGITS(6), .DIV_WIDTH(4), .BRIGHT_WIDTH(4), .HEX_MODE(0)) dut_c (
    .clock(clk), .reset(rst_c), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next frame_start pulse on instance A, bounded.
  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (ifa.frame_start !== 1'b1 && cnt < 500);
    chk("fs_seen", {31'd0, ifa.frame_start}, 32'd1);
  endtask

  logic [6:0] exp_a [4];
  logic [6:0] exp_b [4];
  int cnt, lit0, lit_any, g, last;
  int seq[$];

  initial begin
    ifa.digits = 16'h1234; ifa.dp_en = 4'b1000; ifa.blank_lz = 1'b0; ifa.brightness = 4'hF;
    ifb.digits = 16'hABCF; ifb.dp_en = 4'b0000; ifb.blank_lz = 1'b0; ifb.brightness = 4'hF;
    ifc.digits = 24'h012345; ifc.dp_en = 6'b0; ifc.blank_lz = 1'b0; ifc.brightness = 4'hF;
    adv(2);

    chk("rst_seg", {25'd0, ifa.seg_n}, {25'd0, PBLK});
    chk("rst_dp", {31'd0, ifa.dp_n}, 32'd1);
    chk("rst_an", {28'd0, ifa.an_n}, 32'hF);
    chk("rst_fs", {31'd0, ifa.frame_start}, 32'd0);
    chk("rst_an_c", {26'd0, ifc.an_n}, 32'h3F);

    // First frame after release shows the zeroed shadows.
    rst_ab = 1'b0; rst_c = 1'b0;
    adv(1);
    chk("ff_seg", {25'd0, ifa.seg_n}, {25'd0, P0});
    chk("ff_an", {28'd0, ifa.an_n}, 32'hE);

    // Test 1 + hex decode on instance B
    exp_a = '{P4, P3, P2, P1};
    exp_b = '{PF, PC, PB, PA};
    wait_fs(cnt);
    chk("t1_fs_an_dead", {28'd0, ifa.an_n}, 32'hF);
    for (int k = 0; k < 4; k++) begin
      adv(k == 0 ? 1 : 16);
      chk($sformatf("t1_an%0d", k), {28'd0, ifa.an_n}, {28'd0, ~(4'b0001 << k)});
      chk($sformatf("t1_seg%0d", k), {25'd0, ifa.seg_n}, {25'd0, exp_a[k]});
      chk($sformatf("t1_dp%0d", k), {31'd0, ifa.dp_n}, (k == 3) ? 32'd0 : 32'd1);
      chk($sformatf("t5_hex%0d", k), {25'd0, ifb.seg_n}, {25'd0, exp_b[k]});
    end
    adv(14);
    chk("t1_last_lit", {28'd0, ifa.an_n}, 32'h7);
    wait_fs(cnt);
    chk("t1_deadtime", {28'd0, ifa.an_n}, 32'hF);
    chk("t1_fs_one_cycle", cnt, 1);
    adv(1);
    chk("t1_fs_low", {31'd0, ifa.frame_start}, 32'd0);
    wait_fs(cnt);
    chk("t1_period", cnt, 63);

    // Test 2: leading-zero blanking
    ifa.digits = 16'h0007; ifa.blank_lz = 1'b1; ifa.dp_en = 4'b0000;
    wait_fs(cnt);
    for (int k = 0; k < 4; k++) begin
      adv(k == 0 ? 1 : 16);
      chk($sformatf("t2_an%0d", k), {28'd0, ifa.an_n}, {28'd0, ~(4'b0001 << k)});
      chk($sformatf("t2_seg%0d", k), {25'd0, ifa.seg_n}, {25'd0, (k == 0) ? P7 : PBLK});
    end
    ifa.digits = 16'h0000;
    wait_fs(cnt);
    adv(1);
    chk("t2_zero_d0", {25'd0, ifa.seg_n}, {25'd0, P0});
    adv(16);
    chk("t2_zero_d1", {25'd0, ifa.seg_n}, {25'd0, PBLK});
    chk("t2_zero_an1", {28'd0, ifa.an_n}, 32'hD);

    // Test 3: mid-frame change stays invisible until the next frame
    ifa.digits = 16'h1111; ifa.blank_lz = 1'b0;
    wait_fs(cnt);
    adv(33);
    chk("t3_d2_old", {25'd0, ifa.seg_n}, {25'd0, P1});
    ifa.digits = 16'h2222;
    adv(16);
    chk("t3_d3_old", {25'd0, ifa.seg_n}, {25'd0, P1});
    wait_fs(cnt);
    adv(1);
    chk("t3_new", {25'd0, ifa.seg_n}, {25'd0, P2});

    // Test 4: PWM duty
    ifa.brightness = 4'h4;
    wait_fs(cnt);
    lit0 = 0; lit_any = 0;
    repeat (64) begin
      adv(1);
      if (ifa.an_n[0] == 1'b0) lit0++;
      if (ifa.an_n != 4'hF) lit_any++;
    end
    chk("t4_lit_d0", lit0, 4);
    chk("t4_lit_frame", lit_any, 16);
    ifa.brightness = 4'h0;
    lit_any = 0;
    repeat (64) begin
      adv(1);
      if (ifa.an_n != 4'hF) lit_any++;
    end
    chk("t4_dark", lit_any, 0);
    ifa.brightness = 4'hF;

    // Test 5b: decimal mode shows dashes for A..F
    ifa.digits = 16'hABCF;
    wait_fs(cnt);
    wait_fs(cnt);
    for (int k = 0; k < 4; k++) begin
      adv(k == 0 ? 1 : 16);
      chk($sformatf("t5_dash%0d", k), {25'd0, ifa.seg_n}, {25'd0, PDASH});
    end

    // Test 6: reset on the last count of slot 3 overrides slot_tick
    g = 0;
    while (!(dut_c.idx_q == 3'd3 && dut_c.presc_q == 4'hF) && g < 400) begin
      adv(1);
      g++;
    end
    chk("t6_found", {31'd0, g < 400}, 32'd1);
    rst_c = 1'b1;
    adv(1);
    chk("t6_idx", {29'd0, dut_c.idx_q}, 32'd0);
    chk("t6_presc", {28'd0, dut_c.presc_q}, 32'd0);
    chk("t6_an", {26'd0, ifc.an_n}, 32'h3F);
    chk("t6_seg", {25'd0, ifc.seg_n}, {25'd0, PBLK});
    rst_c = 1'b0;
    last = -1;
    repeat (100) begin
      adv(1);
      if (int'(dut_c.idx_q) != last) begin
        last = int'(dut_c.idx_q);
        seq.push_back(last);
      end
    end
    chk("t6_seq_len", seq.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t6_seq%0d", i), (i < seq.size()) ? seq[i] : -1, i % 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
